// File: rtl/ctrl_unit.sv
// Multicycle control FSM: fetch, decode, ALU/memory/branch sequencing and LM/SM transfers.
// Optional feature: define CTRL_HALT_EN to make opcode 1111 park the FSM in HALT until reset.
//
// state   | meaning
// --------+--------------------------------------------------
// F1      | T1 <= R7 (read PC)
// F2      | IR <= mem[T1], T1 <= R7 + 1
// F3      | R7 <= T1 (PC increment)
// DEC     | decode opcode, no controls
// EX      | ALU operation / address calc / BEQ compare
// WB      | register file write-back (R7 for taken BEQ)
// MEM     | LW read or SW write
// LS_A    | latch base address into tmpA, clear counter
// LS_ADR  | T1 <= tmpA + counter
// LS_XF   | one LM/SM transfer for index counter
// BR      | T1 <= R7 + imm6 (taken branch target)
// HALT    | parked with all enables low

module ctrl_unit #(
  parameter logic [2:0] LAST_CNT = 3'd7
) (
  input  logic        clk,
  input  logic        proc_rst,
  input  logic [15:0] IRout,
  input  logic        compare,
  output logic [2:0]  Mux1_alu_B,
  output logic [2:0]  Mux2_alu_A,
  output logic [1:0]  Mux3_RF_wen,
  output logic [2:0]  Mux4_RF_wadd,
  output logic [1:0]  Mux5_RF_read2,
  output logic        Mux6_RF_dataIn,
  output logic [1:0]  Mux8_memwrite,
  output logic        Mux9_memDataIn,
  output logic        ALU_op,
  output logic        CZ_en,
  output logic        wIR,
  output logic        wAtmp,
  output logic        T1write,
  output logic [2:0]  counter,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_F1, S_F2, S_F3, S_DEC, S_EX, S_WB, S_MEM,
    S_LS_A, S_LS_ADR, S_LS_XF, S_BR, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_counter;
  logic [3:0] w_op;
  logic       w_unused;

  assign w_op     = IRout[15:12];
  // Register fields and CZ condition are consumed by the datapath, not by this FSM.
  assign w_unused = ^IRout[11:0];
  assign counter  = r_counter;

  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      r_state <= S_F1;
    end else begin
      r_state <= w_next;
    end
  end

  // Counter only advances in LS_XF and is held through LS_ADR; zero everywhere else.
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      r_counter <= 3'd0;
    end else if (r_state == S_LS_XF) begin
      if (r_counter == LAST_CNT) begin
        r_counter <= 3'd0;
      end else begin
        r_counter <= r_counter + 3'd1;
      end
    end else if (r_state != S_LS_ADR) begin
      r_counter <= 3'd0;
    end
  end

  always_comb begin
    w_next = S_F1;
    unique case (r_state)
      S_F1:  w_next = S_F2;
      S_F2:  w_next = S_F3;
      S_F3:  w_next = S_DEC;
      S_DEC: begin
        unique case (w_op)
          OP_ADD, OP_ADI, OP_NDU, OP_LHI,
          OP_LW, OP_SW, OP_BEQ:             w_next = S_EX;
          OP_LM, OP_SM:                     w_next = S_LS_A;
`ifdef CTRL_HALT_EN
          OP_HLT:                           w_next = S_HALT;
`endif
          default:                          w_next = S_F1;
        endcase
      end
      S_EX: begin
        unique case (w_op)
          OP_ADD, OP_ADI, OP_NDU, OP_LHI: w_next = S_WB;
          OP_LW, OP_SW:                   w_next = S_MEM;
          OP_BEQ:                         w_next = compare ? S_BR : S_F1;
          default:                        w_next = S_F1;
        endcase
      end
      S_WB:     w_next = S_F1;
      S_MEM:    w_next = S_F1;
      S_BR:     w_next = S_WB;
      S_LS_A:   w_next = S_LS_ADR;
      S_LS_ADR: w_next = S_LS_XF;
      S_LS_XF:  w_next = (r_counter == LAST_CNT) ? S_F1 : S_LS_ADR;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_F1;
    endcase
  end

  always_comb begin
    Mux1_alu_B     = 3'd0;
    Mux2_alu_A     = 3'd0;
    Mux3_RF_wen    = 2'd0;
    Mux4_RF_wadd   = 3'd0;
    Mux5_RF_read2  = 2'd0;
    Mux6_RF_dataIn = 1'b0;
    Mux8_memwrite  = 2'd0;
    Mux9_memDataIn = 1'b0;
    ALU_op         = 1'b0;
    CZ_en          = 1'b0;
    wIR            = 1'b0;
    wAtmp          = 1'b0;
    T1write        = 1'b0;
    unique case (r_state)
      S_F1: begin
        Mux5_RF_read2 = 2'd2;
        Mux2_alu_A    = 3'd0;
        Mux1_alu_B    = 3'd2;
        T1write       = 1'b1;
      end
      S_F2: begin
        wIR           = 1'b1;
        Mux2_alu_A    = 3'd1;
        Mux1_alu_B    = 3'd2;
        Mux5_RF_read2 = 2'd2;
        T1write       = 1'b1;
      end
      S_F3: begin
        Mux6_RF_dataIn = 1'b1;
        Mux4_RF_wadd   = 3'd3;
        Mux3_RF_wen    = 2'd1;
      end
      S_EX: begin
        T1write = 1'b1;
        unique case (w_op)
          OP_ADD, OP_NDU: begin
            Mux2_alu_A = 3'd5;
            Mux1_alu_B = 3'd2;
            CZ_en      = 1'b1;
            ALU_op     = (w_op == OP_NDU);
          end
          OP_ADI: begin
            Mux2_alu_A = 3'd5;
            Mux1_alu_B = 3'd3;
            CZ_en      = 1'b1;
          end
          OP_LHI: begin
            Mux2_alu_A = 3'd2;
            Mux1_alu_B = 3'd0;
          end
          OP_LW, OP_SW: begin
            Mux2_alu_A = 3'd3;
            Mux1_alu_B = 3'd2;
          end
          OP_BEQ: begin
            Mux2_alu_A = 3'd5;
            Mux1_alu_B = 3'd2;
            T1write    = 1'b0;
          end
          default: T1write = 1'b0;
        endcase
      end
      S_WB: begin
        Mux6_RF_dataIn = 1'b1;
        unique case (w_op)
          OP_ADD, OP_NDU: begin
            Mux4_RF_wadd = 3'd1;
            Mux3_RF_wen  = 2'd2;
          end
          OP_ADI: begin
            Mux4_RF_wadd = 3'd4;
            Mux3_RF_wen  = 2'd1;
          end
          OP_LHI: begin
            Mux4_RF_wadd = 3'd0;
            Mux3_RF_wen  = 2'd1;
          end
          OP_BEQ: begin
            Mux4_RF_wadd = 3'd3;
            Mux3_RF_wen  = 2'd1;
          end
          default: Mux6_RF_dataIn = 1'b0;
        endcase
      end
      S_MEM: begin
        if (w_op == OP_LW) begin
          Mux6_RF_dataIn = 1'b0;
          Mux4_RF_wadd   = 3'd0;
          Mux3_RF_wen    = 2'd1;
        end else if (w_op == OP_SW) begin
          Mux8_memwrite  = 2'd1;
          Mux9_memDataIn = 1'b0;
        end
      end
      S_BR: begin
        Mux5_RF_read2 = 2'd2;
        Mux2_alu_A    = 3'd3;
        Mux1_alu_B    = 3'd2;
        T1write       = 1'b1;
      end
      S_LS_A: wAtmp = 1'b1;
      S_LS_ADR: begin
        Mux2_alu_A = 3'd6;
        Mux1_alu_B = 3'd4;
        T1write    = 1'b1;
      end
      S_LS_XF: begin
        if (w_op == OP_LM) begin
          Mux6_RF_dataIn = 1'b0;
          Mux4_RF_wadd   = 3'd2;
          Mux3_RF_wen    = 2'd3;
        end else if (w_op == OP_SM) begin
          Mux5_RF_read2  = 2'd1;
          Mux9_memDataIn = 1'b1;
          Mux8_memwrite  = 2'd2;
        end
      end
      default: ;
    endcase
    // Reset overrides the F1 decode so nothing is enabled while proc_rst is held.
    if (proc_rst) begin
      Mux1_alu_B     = 3'd0;
      Mux2_alu_A     = 3'd0;
      Mux3_RF_wen    = 2'd0;
      Mux4_RF_wadd   = 3'd0;
      Mux5_RF_read2  = 2'd0;
      Mux6_RF_dataIn = 1'b0;
      Mux8_memwrite  = 2'd0;
      Mux9_memDataIn = 1'b0;
      ALU_op         = 1'b0;
      CZ_en          = 1'b0;
      wIR            = 1'b0;
      wAtmp          = 1'b0;
      T1write        = 1'b0;
    end
  end

`ifdef CTRL_HALT_EN
  assign halted = (r_state == S_HALT) && !proc_rst;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed self-checking bench for ctrl_unit; builds with or without CTRL_HALT_EN.
module tb_ctrl_unit;
  logic        clk = 1'b0;
  logic        proc_rst;
  logic [15:0] IRout;
  logic        compare;
  logic [2:0]  Mux1_alu_B, Mux2_alu_A, Mux4_RF_wadd, counter;
  logic [1:0]  Mux3_RF_wen, Mux5_RF_read2, Mux8_memwrite;
  logic        Mux6_RF_dataIn, Mux9_memDataIn, ALU_op, CZ_en, wIR, wAtmp, T1write, halted;
  logic [21:0] obs;

  int nchk = 0;
  int nerr = 0;

  logic [21:0] sF1, sF2, sF3, sDEC, sLSA, sLSADR, sLM, sSM;

  ctrl_unit dut (
    .clk(clk), .proc_rst(proc_rst), .IRout(IRout), .compare(compare),
    .Mux1_alu_B(Mux1_alu_B), .Mux2_alu_A(Mux2_alu_A), .Mux3_RF_wen(Mux3_RF_wen),
    .Mux4_RF_wadd(Mux4_RF_wadd), .Mux5_RF_read2(Mux5_RF_read2),
    .Mux6_RF_dataIn(Mux6_RF_dataIn), .Mux8_memwrite(Mux8_memwrite),
    .Mux9_memDataIn(Mux9_memDataIn), .ALU_op(ALU_op), .CZ_en(CZ_en), .wIR(wIR),
    .wAtmp(wAtmp), .T1write(T1write), .counter(counter), .halted(halted)
  );

  always #5 clk = ~clk;

  assign obs = {Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
                Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, ALU_op, CZ_en,
                wIR, wAtmp, T1write};

  // Argument order: Mux1, Mux2, Mux3, Mux4, Mux5, Mux6, Mux8, Mux9, ALU_op, CZ_en, wIR, wAtmp, T1write
  function automatic logic [21:0] mk(input int m1, m2, m3, m4, m5, m6, m8, m9,
                                     alu, cz, wir, wa, t1);
    logic [2:0] a1, a2, a4;
    logic [1:0] b3, b5, b8;
    logic       c6, c9, c10, c11, c12, c13, c14;
    a1 = m1[2:0]; a2 = m2[2:0]; b3 = m3[1:0]; a4 = m4[2:0]; b5 = m5[1:0];
    c6 = m6[0]; b8 = m8[1:0]; c9 = m9[0]; c10 = alu[0]; c11 = cz[0];
    c12 = wir[0]; c13 = wa[0]; c14 = t1[0];
    return {a1, a2, b3, a4, b5, c6, b8, c9, c10, c11, c12, c13, c14};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [21:0] exp [4];
    proc_rst = 1'b1;
    IRout    = 16'h8000;
    compare  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    nchk++; if (obs !== 22'd0) begin nerr++; $display("FAIL rst_ctrl got %h want %h", obs, 22'd0); end
    nchk++; if (counter !== 3'd0) begin nerr++; $display("FAIL rst_counter got %0d want 0", counter); end
    nchk++; if (halted !== 1'b0) begin nerr++; $display("FAIL rst_halted got %0b want 0", halted); end
    @(negedge clk);
    proc_rst = 1'b0;
    #1;
    nchk++; if (obs !== sF1) begin nerr++; $display("FAIL rst_release_f1 got %h want %h", obs, sF1); end
    cyc();
    nchk++; if (obs !== sF2) begin nerr++; $display("FAIL rst_f2 got %h want %h", obs, sF2); end
    #2 proc_rst = 1'b1;
    #1;
    nchk++; if (wIR !== 1'b0) begin nerr++; $display("FAIL rst_midf2_wir got %0b want 0", wIR); end
    nchk++; if (obs !== 22'd0) begin nerr++; $display("FAIL rst_midf2_ctrl got %h want %h", obs, 22'd0); end
    #1 proc_rst = 1'b0;
    #1;
    nchk++; if (obs !== sF1) begin nerr++; $display("FAIL rst_midf2_state got %h want %h", obs, sF1); end
    nchk++; if (counter !== 3'd0) begin nerr++; $display("FAIL rst_midf2_counter got %0d want 0", counter); end
    // Opcode 1000 is undefined: F2, F3, DEC, back to F1.
    exp = '{sF2, sF3, sDEC, sF1};
    for (int i = 0; i < 4; i++) begin
      cyc();
      nchk++; if (obs !== exp[i]) begin nerr++; $display("FAIL rst_other_seq[%0d] got %h want %h", i, obs, exp[i]); end
    end
  endtask

  task automatic test_add();
    logic [21:0] exp [7];
    IRout = {4'b0000, 3'd1, 3'd2, 3'd3, 3'b000};
    exp = '{sF1, sF2, sF3, sDEC,
            mk(2, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1),
            mk(0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0),
            sF1};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) cyc();
      nchk++; if (obs !== exp[i]) begin nerr++; $display("FAIL add_seq[%0d] got %h want %h", i, obs, exp[i]); end
    end
  endtask

  task automatic test_instr_table();
    logic [3:0]  ops [5];
    logic [21:0] exs [5];
    logic [21:0] nxs [5];
    logic [21:0] exp [7];
    ops = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
    exs = '{mk(3, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1),
            mk(2, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1),
            mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
            mk(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
            mk(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    nxs = '{mk(0, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0),
            mk(0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0),
            mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0),
            mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
            mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
    for (int k = 0; k < 5; k++) begin
      IRout = {ops[k], 12'h2C5};
      exp = '{sF1, sF2, sF3, sDEC, exs[k], nxs[k], sF1};
      for (int i = 0; i < 7; i++) begin
        if (i > 0) cyc();
        nchk++; if (obs !== exp[i]) begin nerr++; $display("FAIL op%0b_seq[%0d] got %h want %h", ops[k], i, obs, exp[i]); end
      end
    end
  endtask

  task automatic test_beq();
    logic [21:0] tk [8];
    logic [21:0] nt [6];
    logic [21:0] ex_beq;
    ex_beq = mk(2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    IRout   = {4'b1100, 3'd1, 3'd2, 6'd5};
    compare = 1'b1;
    tk = '{sF1, sF2, sF3, sDEC, ex_beq,
           mk(2, 3, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1),
           mk(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0),
           sF1};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      nchk++; if (obs !== tk[i]) begin nerr++; $display("FAIL beq_taken[%0d] got %h want %h", i, obs, tk[i]); end
    end
    compare = 1'b0;
    nt = '{sF1, sF2, sF3, sDEC, ex_beq, sF1};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      nchk++; if (obs !== nt[i]) begin nerr++; $display("FAIL beq_not_taken[%0d] got %h want %h", i, obs, nt[i]); end
    end
  endtask

  task automatic test_lm();
    logic [21:0] exp [4];
    IRout = {4'b0110, 3'd3, 1'b0, 8'hA5};
    exp = '{sF1, sF2, sF3, sDEC};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      nchk++; if (obs !== exp[i]) begin nerr++; $display("FAIL lm_fetch[%0d] got %h want %h", i, obs, exp[i]); end
    end
    cyc();
    nchk++; if (obs !== sLSA) begin nerr++; $display("FAIL lm_lsa got %h want %h", obs, sLSA); end
    nchk++; if (counter !== 3'd0) begin nerr++; $display("FAIL lm_lsa_counter got %0d want 0", counter); end
    for (int i = 0; i < 8; i++) begin
      cyc();
      nchk++; if (obs !== sLSADR || counter !== 3'(i)) begin nerr++; $display("FAIL lm_adr[%0d] got %h/%0d want %h/%0d", i, obs, counter, sLSADR, i); end
      cyc();
      nchk++; if (obs !== sLM || counter !== 3'(i)) begin nerr++; $display("FAIL lm_xf[%0d] got %h/%0d want %h/%0d", i, obs, counter, sLM, i); end
    end
    cyc();
    nchk++; if (obs !== sF1 || counter !== 3'd0) begin nerr++; $display("FAIL lm_done got %h/%0d want %h/0", obs, counter, sF1); end
  endtask

  task automatic test_sm_empty();
    IRout = {4'b0111, 3'd2, 1'b0, 8'h00};
    repeat (4) cyc();
    nchk++; if (obs !== sLSA) begin nerr++; $display("FAIL sm_lsa got %h want %h", obs, sLSA); end
    for (int i = 0; i < 8; i++) begin
      cyc();
      cyc();
      nchk++; if (obs !== sSM || counter !== 3'(i)) begin nerr++; $display("FAIL sm_xf[%0d] got %h/%0d want %h/%0d", i, obs, counter, sSM, i); end
    end
    cyc();
    nchk++; if (obs !== sF1 || counter !== 3'd0) begin nerr++; $display("FAIL sm_done got %h/%0d want %h/0", obs, counter, sF1); end
  endtask

  task automatic test_reset_ls();
    IRout = {4'b0111, 3'd1, 1'b0, 8'hFF};
    repeat (4) cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      cyc();
    end
    nchk++; if (counter !== 3'd4 || Mux8_memwrite !== 2'd2) begin nerr++; $display("FAIL rstls_pre got cnt=%0d m8=%0d want cnt=4 m8=2", counter, Mux8_memwrite); end
    #2 proc_rst = 1'b1;
    #1;
    nchk++; if (counter !== 3'd0) begin nerr++; $display("FAIL rstls_counter got %0d want 0", counter); end
    nchk++; if (Mux8_memwrite !== 2'd0 || obs !== 22'd0) begin nerr++; $display("FAIL rstls_ctrl got %h want %h", obs, 22'd0); end
    #1 proc_rst = 1'b0;
    #1;
    nchk++; if (obs !== sF1) begin nerr++; $display("FAIL rstls_state got %h want %h", obs, sF1); end
  endtask

  task automatic test_halt();
    IRout = 16'hF000;
    repeat (4) cyc();
`ifdef CTRL_HALT_EN
    for (int i = 0; i < 20; i++) begin
      nchk++; if (halted !== 1'b1 || obs !== 22'd0) begin nerr++; $display("FAIL halt[%0d] got h=%0b %h want h=1 0", i, halted, obs); end
      cyc();
    end
    #2 proc_rst = 1'b1;
    #2 proc_rst = 1'b0;
    #1;
    nchk++; if (halted !== 1'b0 || obs !== sF1) begin nerr++; $display("FAIL halt_exit got h=%0b %h want h=0 %h", halted, obs, sF1); end
`else
    nchk++; if (halted !== 1'b0 || obs !== sF1) begin nerr++; $display("FAIL halt_off got h=%0b %h want h=0 %h", halted, obs, sF1); end
`endif
  endtask

  initial begin
    sF1    = mk(2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    sF2    = mk(2, 1, 0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 1);
    sF3    = mk(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    sDEC   = 22'd0;
    sLSA   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    sLSADR = mk(4, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    sLM    = mk(0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sSM    = mk(0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0);
    test_reset();
    test_add();
    test_instr_table();
    test_beq();
    test_lm();
    test_sm_empty();
    test_reset_ls();
    test_halt();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
